// File: rtl/mem_access_unit.sv
// Load/store alignment unit between EX/MEM and a word-only data memory; sub-word stores use a 2-cycle read-modify-write.
// Optional macro MISALIGN_TRAP_EN: drop misaligned H/W requests and pulse misaligned_o instead of forcing alignment.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic [DATA_WIDTH-1:0] dm_read_data_i,
    output logic                  dm_mem_read_o,
    output logic                  dm_mem_write_o,
    output logic [ADDR_WIDTH-1:0] dm_address_o,
    output logic [DATA_WIDTH-1:0] dm_write_data_o,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic                  load_valid_o,
    output logic                  misaligned_o
);

    typedef enum logic [0:0] {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

    state_t                  state_r, next_state_s;
    logic [DATA_WIDTH-1:0]   merge_r, merge_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_next_s;
    logic [DATA_WIDTH-1:0]   load_data_r, load_data_next_s;
    logic                    load_valid_r, load_valid_next_s;
    logic                    misaligned_r, misaligned_next_s;
    logic                    rd_s, wr_s, stall_s;
    logic                    is_byte_s, is_half_s, is_word_s, misaligned_s;
    logic [1:0]              offset_s;
    logic [ADDR_WIDTH-1:0]   aligned_s;

    // Insert the byte or halfword store data into the word read back from memory.
    function automatic logic [31:0] merge_word(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] off, input logic is_half);
        logic [31:0] m;
        m = word;
        if (is_half) begin
            if (off[1]) m[31:16] = wdata[15:0];
            else        m[15:0]  = wdata[15:0];
        end else begin
            case (off)
                2'd0:    m[7:0]   = wdata[7:0];
                2'd1:    m[15:8]  = wdata[7:0];
                2'd2:    m[23:16] = wdata[7:0];
                default: m[31:24] = wdata[7:0];
            endcase
        end
        return m;
    endfunction

    // Shift the addressed lane down and sign- or zero-extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [2:0] f3);
        logic [31:0] s;
        logic        sgn;
        s = word >> {off, 3'b000};
        case (f3[1:0])
            2'b00: begin
                sgn = ~f3[2] & s[7];
                extract_load = {{24{sgn}}, s[7:0]};
            end
            2'b01: begin
                sgn = ~f3[2] & s[15];
                extract_load = {{16{sgn}}, s[15:0]};
            end
            default: extract_load = word;
        endcase
    endfunction

    assign is_byte_s = (funct3_i[1:0] == 2'b00);
    assign is_half_s = (funct3_i[1:0] == 2'b01);
    assign is_word_s = ~is_byte_s & ~is_half_s;
    assign aligned_s = {address_i[ADDR_WIDTH-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
    assign offset_s     = address_i[1:0];
    assign misaligned_s = (is_half_s & address_i[0]) | (is_word_s & (|address_i[1:0]));
`else
    assign offset_s     = is_word_s ? 2'b00 : (is_half_s ? {address_i[1], 1'b0} : address_i[1:0]);
    assign misaligned_s = 1'b0;
`endif

    // Next-state, memory handshake and next values of the result registers.
    always_comb begin
        next_state_s      = state_r;
        rd_s              = 1'b0;
        wr_s              = 1'b0;
        stall_s           = 1'b0;
        dm_address_o      = aligned_s;
        dm_write_data_o   = write_data_i;
        merge_next_s      = merge_r;
        addr_next_s       = addr_r;
        load_data_next_s  = load_data_r;
        load_valid_next_s = 1'b0;
        misaligned_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                if ((mem_read_i | mem_write_i) & misaligned_s) begin
                    misaligned_next_s = 1'b1;
                end else if (mem_write_i) begin
                    if (is_word_s) begin
                        wr_s = 1'b1;
                    end else begin
                        // Sub-word store: fetch the word now, write the merge next cycle.
                        rd_s         = 1'b1;
                        stall_s      = 1'b1;
                        merge_next_s = merge_word(dm_read_data_i, write_data_i, offset_s, is_half_s);
                        addr_next_s  = aligned_s;
                        next_state_s = RMW_WR;
                    end
                end else if (mem_read_i) begin
                    rd_s              = 1'b1;
                    load_valid_next_s = 1'b1;
                    load_data_next_s  = extract_load(dm_read_data_i, offset_s, funct3_i);
                end else begin
                    next_state_s = IDLE;
                end
            end
            RMW_WR: begin
                wr_s            = 1'b1;
                dm_write_data_o = merge_r;
                dm_address_o    = addr_r;
                next_state_s    = IDLE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Enables are forced low while reset is held so no access escapes during reset.
    assign dm_mem_read_o  = rd_s & reset;
    assign dm_mem_write_o = wr_s & reset;
    assign stall_o        = stall_s & reset;

    // State and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            merge_r      <= 32'h0000_0000;
            addr_r       <= {ADDR_WIDTH{1'b0}};
            load_data_r  <= 32'h0000_0000;
            load_valid_r <= 1'b0;
            misaligned_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            merge_r      <= merge_next_s;
            addr_r       <= addr_next_s;
            load_data_r  <= load_data_next_s;
            load_valid_r <= load_valid_next_s;
            misaligned_r <= misaligned_next_s;
        end
    end

    assign load_data_o  = load_data_r;
    assign load_valid_o = load_valid_r;
    assign misaligned_o = misaligned_r;

endmodule
